// File: rtl/packet_reader_pkg.sv
// -----------------------------------------------------------------------------
// packet_reader_pkg
//   Shared definitions for the per-port packet reader: default flit width and
//   FIFO depth, the controller state encoding, and a small state helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package packet_reader_pkg;

   localparam int TAM_FLIT   = 16;  // flit width in bits
   localparam int TAM_BUFFER = 8;   // input FIFO depth

   // 3-bit state encoding; unused codes fall back to IDLE.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_TX_HDR  = 3'd2,
      S_TX_SIZE = 3'd3,
      S_TX_PAY  = 3'd4
   } state_t;

   // True while the port owns a crossbar connection and streams flits.
   function automatic logic is_tx(input state_t s);
      return (s == S_TX_HDR) || (s == S_TX_SIZE) || (s == S_TX_PAY);
   endfunction

endpackage

// File: rtl/packet_reader.sv
// -----------------------------------------------------------------------------
// packet_reader
//   Per-port forwarding controller sitting on the head of the input FIFO.
//   Latches the header flit, requests a route, then streams header, size and
//   S payload flits to the crossbar under a valid/ack handshake. A flit is
//   pulled from the FIFO in exactly the cycle it is accepted downstream.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   fifo_head     in   current FIFO head flit
//   fifo_counter  in   FIFO occupancy
//   fifo_pull     out  pop strobe; the FIFO pops on the next edge
//   h             out  routing request to switch control
//   ack_h         in   routing granted (pulse or level)
//   header        out  latched header flit (target address)
//   data_out      out  flit to crossbar (always the FIFO head)
//   data_av       out  data_out valid
//   data_ack      in   crossbar accepts data_out this cycle
//   sender        out  port owns a connection (grant .. last flit)
// -----------------------------------------------------------------------------
module packet_reader
   import packet_reader_pkg::*;
#(
   parameter int WIDTH = TAM_FLIT,
   parameter int DEPTH = TAM_BUFFER
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       fifo_head,
   input  logic [$clog2(DEPTH):0] fifo_counter,
   output logic                   fifo_pull,
   output logic                   h,
   input  logic                   ack_h,
   output logic [WIDTH-1:0]       header,
   output logic [WIDTH-1:0]       data_out,
   output logic                   data_av,
   input  logic                   data_ack,
   output logic                   sender
);

   state_t           state, state_next;
   logic [WIDTH-1:0] flits_left, flits_left_next;
   logic [WIDTH-1:0] header_next;
   logic             fifo_has_flit;
   logic             transfer;

   assign fifo_has_flit = (fifo_counter != '0);

   // The crossbar sees the FIFO head directly; validity is qualified by data_av.
   assign data_out = fifo_head;

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         header     <= '0;
         flits_left <= '0;
      end else begin
         state      <= state_next;
         header     <= header_next;
         flits_left <= flits_left_next;
      end
   end

   // NOTE: every variable driven here gets a default first, so no branch can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next      = state;
      header_next     = header;
      flits_left_next = flits_left;
      h               = 1'b0;
      data_av         = 1'b0;
      transfer        = 1'b0;
      fifo_pull       = 1'b0;
      sender          = is_tx(state);

      // Handshake only exists while streaming; an empty FIFO mid-packet simply
      // drops data_av and the state holds until the next flit shows up.
      if (is_tx(state)) begin
         data_av   = fifo_has_flit;
         transfer  = fifo_has_flit & data_ack;
         fifo_pull = transfer;
      end

      case (state)
         S_IDLE: begin
            if (fifo_has_flit) begin
               header_next = fifo_head;
               state_next  = S_REQ;
            end
         end

         S_REQ: begin
            h = 1'b1;
            if (ack_h) state_next = S_TX_HDR;
         end

         S_TX_HDR: begin
            if (transfer) state_next = S_TX_SIZE;
         end

         S_TX_SIZE: begin
            if (transfer) begin
               flits_left_next = fifo_head;
               // A zero-size packet ends with its size flit.
               state_next      = (fifo_head == '0) ? S_IDLE : S_TX_PAY;
            end
         end

         S_TX_PAY: begin
            if (transfer) begin
               // TX_PAY is only entered with a non-zero count; the guard keeps
               // the counter from wrapping even if that were ever violated.
               if (flits_left != '0) flits_left_next = flits_left - WIDTH'(1);
               if (flits_left <= WIDTH'(1)) state_next = S_IDLE;
            end
         end

         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_packet_reader.sv
// -----------------------------------------------------------------------------
// tb_packet_reader
//   Directed bench for packet_reader. A small FIFO model feeds the DUT; the
//   stimulus pushes every flit that must appear on the crossbar into an
//   expected queue, and an independent monitor compares data_out against the
//   queue head whenever data_av is high, popping on each accepted transfer.
// -----------------------------------------------------------------------------
module tb_packet_reader;
   import packet_reader_pkg::*;

   localparam int W  = 16;
   localparam int D  = 8;
   localparam int CW = $clog2(D) + 1;

   logic          clock = 1'b0;
   logic          reset;
   logic [W-1:0]  fifo_head;
   logic [CW-1:0] fifo_counter;
   logic          fifo_pull;
   logic          h;
   logic          ack_h;
   logic [W-1:0]  header;
   logic [W-1:0]  data_out;
   logic          data_av;
   logic          data_ack;
   logic          sender;

   logic [W-1:0]  fifo_q[$];
   logic [W-1:0]  exp_q[$];
   int            checks   = 0;
   int            failures = 0;
   int            ack_seq[5] = '{1, 0, 0, 1, 1};
   int            fl;

   packet_reader #(.WIDTH(W), .DEPTH(D)) dut (
      .clock        (clock),
      .reset        (reset),
      .fifo_head    (fifo_head),
      .fifo_counter (fifo_counter),
      .fifo_pull    (fifo_pull),
      .h            (h),
      .ack_h        (ack_h),
      .header       (header),
      .data_out     (data_out),
      .data_av      (data_av),
      .data_ack     (data_ack),
      .sender       (sender)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic refresh();
      fifo_head    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
      fifo_counter = CW'(fifo_q.size());
   endtask

   // Push a flit into the FIFO model; expected flits also go to the scoreboard.
   task automatic push(input logic [W-1:0] v, input bit expected);
      fifo_q.push_back(v);
      if (expected) exp_q.push_back(v);
      refresh();
   endtask

   // One clock: sample pull/reset just before the edge, then update the FIFO
   // model right after it, as a real FIFO would.
   task automatic cycle();
      logic pull_s, rst_s;
      @(negedge clock);
      pull_s = fifo_pull;
      rst_s  = reset;
      @(posedge clock);
      #1;
      if (rst_s) fifo_q.delete();
      else if (pull_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
      refresh();
      #1;
   endtask

   task automatic wait_h();
      int n = 0;
      while (h !== 1'b1 && n < 20) begin
         cycle();
         n++;
      end
      check("h_wait", 32'(h), 32'd1);
   endtask

   task automatic grant();
      ack_h = 1'b1;
      cycle();
      ack_h = 1'b0;
      #1;
   endtask

   // Scoreboard monitor.
   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (data_av === 1'b1) begin
            check("av_nonempty", 32'(fifo_counter != 0), 32'd1);
            check("av_sender", 32'(sender), 32'd1);
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               check("data_out", 32'(data_out), 32'(exp_q[0]));
               check("pull_on_ack", 32'(fifo_pull), 32'(data_ack));
               if (data_ack === 1'b1) void'(exp_q.pop_front());
            end
         end else begin
            check("pull_without_av", 32'(fifo_pull), 32'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- reset with a non-empty FIFO ----------------
      reset    = 1'b1;
      ack_h    = 1'b0;
      data_ack = 1'b1;
      fifo_q.delete();
      refresh();
      cycle();
      push(16'h1111, 1'b0);
      push(16'h2222, 1'b0);
      push(16'h0003, 1'b0);
      #1;
      check("rst_h", 32'(h), 32'd0);
      check("rst_av", 32'(data_av), 32'd0);
      check("rst_pull", 32'(fifo_pull), 32'd0);
      check("rst_sender", 32'(sender), 32'd0);
      cycle();
      check("rst_header", 32'(header), 32'd0);
      check("rst_state", 32'(dut.state), 32'(S_IDLE));
      check("rst_flits_left", 32'(dut.flits_left), 32'd0);
      reset = 1'b0;
      #1;

      // ---------------- basic packet ----------------
      push(16'h0011, 1'b1);
      push(16'h0002, 1'b1);
      push(16'hAAAA, 1'b1);
      push(16'hBBBB, 1'b1);
      #1;
      check("b_h_early", 32'(h), 32'd0);
      cycle();
      check("b_h_rise", 32'(h), 32'd1);
      check("b_header", 32'(header), 32'h0011);
      cycle();
      check("b_h_hold", 32'(h), 32'd1);
      cycle();
      ack_h = 1'b1;
      #1;
      check("b_h_at_ack", 32'(h), 32'd1);
      cycle();
      ack_h = 1'b0;
      #1;
      check("b_h_fall", 32'(h), 32'd0);
      check("b_sender_up", 32'(sender), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("b_pull", 32'(fifo_pull), 32'd1);
         cycle();
      end
      check("b_sender_down", 32'(sender), 32'd0);
      check("b_state_idle", 32'(dut.state), 32'(S_IDLE));
      check("b_sb_drained", 32'(exp_q.size()), 32'd0);

      // ---------------- ack_h / data_ack ignored while idle ----------------
      ack_h = 1'b1;
      #1;
      check("idle_pull", 32'(fifo_pull), 32'd0);
      cycle();
      check("idle_ack_h_ignored", 32'(dut.state), 32'(S_IDLE));
      check("idle_h", 32'(h), 32'd0);
      ack_h = 1'b0;
      #1;

      // ---------------- zero-size packet ----------------
      push(16'h0022, 1'b1);
      push(16'h0000, 1'b1);
      cycle();
      check("z_h", 32'(h), 32'd1);
      check("z_header", 32'(header), 32'h0022);
      grant();
      for (int i = 0; i < 2; i++) begin
         check("z_not_pay", 32'(dut.state == S_TX_PAY), 32'd0);
         check("z_pull", 32'(fifo_pull), 32'd1);
         cycle();
      end
      check("z_idle", 32'(dut.state), 32'(S_IDLE));
      check("z_sender", 32'(sender), 32'd0);

      // ---------------- backpressure during payload ----------------
      push(16'h0033, 1'b1);
      push(16'h0003, 1'b1);
      push(16'h0C01, 1'b1);
      push(16'h0C02, 1'b1);
      push(16'h0C03, 1'b1);
      wait_h();
      grant();
      cycle();
      cycle();
      check("bp_in_pay", 32'(dut.state), 32'(S_TX_PAY));
      check("bp_fl_load", 32'(dut.flits_left), 32'd3);
      fl = 3;
      for (int i = 0; i < 5; i++) begin
         data_ack = ack_seq[i][0];
         #1;
         check("bp_av", 32'(data_av), 32'd1);
         check("bp_pull", 32'(fifo_pull), 32'(ack_seq[i]));
         fl -= ack_seq[i];
         cycle();
         check("bp_flits_left", 32'(dut.flits_left), 32'(fl));
      end
      check("bp_idle", 32'(dut.state), 32'(S_IDLE));
      data_ack = 1'b1;
      #1;

      // ---------------- FIFO underrun mid-payload ----------------
      push(16'h0044, 1'b1);
      push(16'h0002, 1'b1);
      wait_h();
      grant();
      cycle();
      cycle();
      for (int i = 0; i < 5; i++) begin
         check("u_av_low", 32'(data_av), 32'd0);
         check("u_hold_pay", 32'(dut.state), 32'(S_TX_PAY));
         check("u_no_pull", 32'(fifo_pull), 32'd0);
         cycle();
      end
      push(16'h0D01, 1'b1);
      push(16'h0D02, 1'b1);
      #1;
      check("u_av_resume", 32'(data_av), 32'd1);
      cycle();
      cycle();
      check("u_idle", 32'(dut.state), 32'(S_IDLE));
      check("u_sb_drained", 32'(exp_q.size()), 32'd0);

      // ---------------- reset mid-packet, then a clean packet ----------------
      push(16'h0055, 1'b1);
      push(16'h0004, 1'b1);
      push(16'h0E01, 1'b1);
      push(16'h0E02, 1'b1);
      push(16'h0E03, 1'b1);
      push(16'h0E04, 1'b1);
      wait_h();
      grant();
      cycle();
      cycle();
      cycle();
      check("mr_fl_before", 32'(dut.flits_left), 32'd3);
      reset = 1'b1;
      exp_q.delete();
      cycle();
      reset = 1'b0;
      #1;
      check("mr_state", 32'(dut.state), 32'(S_IDLE));
      check("mr_h", 32'(h), 32'd0);
      check("mr_sender", 32'(sender), 32'd0);
      check("mr_header", 32'(header), 32'd0);
      check("mr_flits_left", 32'(dut.flits_left), 32'd0);
      push(16'h0066, 1'b1);
      push(16'h0001, 1'b1);
      push(16'h0F01, 1'b1);
      wait_h();
      check("mr_new_header", 32'(header), 32'h0066);
      grant();
      cycle();
      cycle();
      cycle();
      check("mr_new_idle", 32'(dut.state), 32'(S_IDLE));

      data_ack = 1'b0;
      cycle();
      check("final_sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
